fht_ram_reader: RTL and testbench

//   Unload engine for the 4-bank FHT result RAM. On iSTART, issues reads of all
//   4*DEPTH points over the bank read ports and streams them out one point per

---
 rtl/fht_pkg.sv | 27 ++
 rtl/fht_rd_skid_fifo.sv | 48 ++++
 rtl/fht_ram_reader.sv | 190 +++++++++++++++++++
 tb/tb_fht_ram_reader.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fht_pkg.sv
// Shared types and sizing helpers for the FHT result-RAM unload path.
// Build option: FHT_RD_BITREV_EN selects bit-reversed stream order.
package fht_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_D_BIT  = 17;
  localparam int DEF_A_BIT  = 8;
  localparam int DEF_RD_LAT = 1;

  function automatic int n_pts(input int depth);
    return 4 * depth;
  endfunction

  function automatic int idx_bit(input int a_bit);
    return a_bit + 2;
  endfunction

  function automatic int fifo_depth(input int rd_lat);
    return rd_lat + 2;
  endfunction

endpackage

// File: rtl/fht_rd_skid_fifo.sv
// Small register-based skid FIFO holding {last, data}; head is visible
// combinationally and the occupancy is exported for the issue credit check.
module fht_rd_skid_fifo
  import fht_pkg::*;
#(
  parameter int W     = DEF_D_BIT + 1,
  parameter int DEPTH = fifo_depth(DEF_RD_LAT),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [W-1:0]     i_wdata,
  input  logic             i_pop,
  output logic [W-1:0]     o_rdata,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= (r_wr == PTR_LAST) ? '0 : r_wr + 1'b1;
      if (i_pop)  r_rd <= (r_rd == PTR_LAST) ? '0 : r_rd + 1'b1;
      r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

// File: rtl/fht_ram_reader.sv
// Unload engine: reads all 4*DEPTH points from the 4 result banks and streams
// them on valid/ready. Define FHT_RD_BITREV_EN for bit-reversed stream order.
module fht_ram_reader
  import fht_pkg::*;
#(
  parameter int D_BIT  = DEF_D_BIT,
  parameter int A_BIT  = DEF_A_BIT,
  parameter int DEPTH  = 2 ** A_BIT,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic             iSTART,
  output logic [A_BIT-1:0] oADDR_RD_0,
  output logic [A_BIT-1:0] oADDR_RD_1,
  output logic [A_BIT-1:0] oADDR_RD_2,
  output logic [A_BIT-1:0] oADDR_RD_3,
  input  logic [D_BIT-1:0] iDATA_0,
  input  logic [D_BIT-1:0] iDATA_1,
  input  logic [D_BIT-1:0] iDATA_2,
  input  logic [D_BIT-1:0] iDATA_3,
  output logic [D_BIT-1:0] oDATA,
  output logic             oVALID,
  input  logic             iREADY,
  output logic             oLAST,
  output logic             oBUSY,
  output logic             oDONE
);

  localparam int N_PTS_L = n_pts(DEPTH);
  localparam int IDX_W   = idx_bit(A_BIT);
  localparam int FD      = fifo_depth(RD_LAT);
  localparam int CNT_W   = $clog2(FD + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS_L - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [IDX_W-1:0]   r_n;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_map;
  logic               w_issue;
  logic               w_done_next;
  logic [A_BIT-1:0]   r_addr;
  logic               r_iss_v;
  logic               r_iss_last;
  logic [1:0]         r_iss_bank;
  logic [RD_LAT-1:0]  r_pv;
  logic [RD_LAT-1:0]  r_plast;
  logic [1:0]         r_pbank [RD_LAT];
  logic [D_BIT-1:0]   w_q;
  logic [D_BIT:0]     w_rdata;
  logic               w_empty;
  logic [CNT_W-1:0]   w_count;
  logic               w_pop;
  logic [3:0]         w_used;
  logic               w_credit_ok;
  logic [D_BIT-1:0]   r_hold;
  logic               r_done;

  genvar gi;
  generate
    for (gi = 0; gi < IDX_W; gi++) begin : g_map
`ifdef FHT_RD_BITREV_EN
      assign w_map[gi] = w_idx[IDX_W-1-gi];
`else
      assign w_map[gi] = w_idx[gi];
`endif
    end
  endgenerate

  // Slots committed = FIFO contents + every read still on its way back; a beat
  // leaving this cycle frees its slot in time for the next issue.
  always_comb begin
    w_used = 4'(w_count) + 4'(r_iss_v);
    for (int k = 0; k < RD_LAT; k++) w_used = w_used + 4'(r_pv[k]);
    w_used = w_used - 4'(w_pop);
  end
  assign w_credit_ok = (w_used < 4'(FD));

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_state <= ST_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_idx        = r_n;
    w_done_next  = 1'b0;
    unique case (r_state)
      ST_IDLE: if (iSTART) begin
        w_issue      = 1'b1;
        w_idx        = '0;
        w_state_next = ST_RUN;
      end
      ST_RUN: if (w_credit_ok) begin
        w_issue = 1'b1;
        if (r_n == LAST_IDX) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: if (w_pop && w_rdata[D_BIT]) begin
        w_state_next = ST_IDLE;
        w_done_next  = 1'b1;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_n        <= '0;
      r_addr     <= '0;
      r_iss_v    <= 1'b0;
      r_iss_last <= 1'b0;
      r_iss_bank <= '0;
    end else begin
      r_iss_v <= w_issue;
      if (w_issue) begin
        r_addr     <= w_map[IDX_W-1:2];
        r_iss_bank <= w_map[1:0];
        r_iss_last <= (w_idx == LAST_IDX);
        r_n        <= (w_idx == LAST_IDX) ? w_idx : w_idx + 1'b1;
      end
    end
  end

  // Bank select and last tag ride alongside the RAM read latency.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      r_pv    <= '0;
      r_plast <= '0;
      for (int k = 0; k < RD_LAT; k++) r_pbank[k] <= '0;
    end else begin
      r_pv[0]    <= r_iss_v;
      r_plast[0] <= r_iss_last;
      r_pbank[0] <= r_iss_bank;
      for (int k = 1; k < RD_LAT; k++) begin
        r_pv[k]    <= r_pv[k-1];
        r_plast[k] <= r_plast[k-1];
        r_pbank[k] <= r_pbank[k-1];
      end
    end
  end

  always_comb begin
    w_q = iDATA_0;
    case (r_pbank[RD_LAT-1])
      2'd1:    w_q = iDATA_1;
      2'd2:    w_q = iDATA_2;
      2'd3:    w_q = iDATA_3;
      default: w_q = iDATA_0;
    endcase
  end

  fht_rd_skid_fifo #(
    .W     (D_BIT + 1),
    .DEPTH (FD),
    .CNT_W (CNT_W)
  ) u_fifo (
    .i_clk   (iCLK),
    .i_rst_n (iRESET),
    .i_push  (r_pv[RD_LAT-1]),
    .i_wdata ({r_plast[RD_LAT-1], w_q}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET)    r_hold <= '0;
    else if (w_pop) r_hold <= w_rdata[D_BIT-1:0];
  end

  assign w_pop      = !w_empty && iREADY;
  assign oVALID     = !w_empty;
  assign oDATA      = w_empty ? r_hold : w_rdata[D_BIT-1:0];
  assign oLAST      = !w_empty && w_rdata[D_BIT];
  assign oBUSY      = (r_state != ST_IDLE);
  assign oDONE      = r_done;
  assign oADDR_RD_0 = r_addr;
  assign oADDR_RD_1 = r_addr;
  assign oADDR_RD_2 = r_addr;
  assign oADDR_RD_3 = r_addr;

endmodule

// File: tb/tb_fht_ram_reader.sv
// Scoreboard bench for fht_ram_reader: expected beats are queued at start,
// a negedge monitor pops and compares each transferred beat.
module tb_fht_ram_reader;

`ifdef FHT_RD_BITREV_EN
  localparam int A_BIT = 2;
`else
  localparam int A_BIT = 8;
`endif
  localparam int D_BIT    = 17;
  localparam int DEPTH    = 2 ** A_BIT;
  localparam int RD_LAT   = 1;
  localparam int N        = 4 * DEPTH;
  localparam int FD       = RD_LAT + 2;
  localparam int RST_BEAT = (N > 600) ? 300 : N / 2;

`ifdef FHT_RD_BITREV_EN
  localparam int BR_TAB [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             ready;
  logic [A_BIT-1:0] a0, a1, a2, a3;
  logic [D_BIT-1:0] q0, q1, q2, q3;
  logic [D_BIT-1:0] odata;
  logic             ovalid, olast, obusy, odone;

  fht_ram_reader #(
    .D_BIT  (D_BIT),
    .A_BIT  (A_BIT),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .iCLK       (clk),
    .iRESET     (rst_n),
    .iSTART     (start),
    .oADDR_RD_0 (a0),
    .oADDR_RD_1 (a1),
    .oADDR_RD_2 (a2),
    .oADDR_RD_3 (a3),
    .iDATA_0    (q0),
    .iDATA_1    (q1),
    .iDATA_2    (q2),
    .iDATA_3    (q3),
    .oDATA      (odata),
    .oVALID     (ovalid),
    .iREADY     (ready),
    .oLAST      (olast),
    .oBUSY      (obusy),
    .oDONE      (odone)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bank k at address a holds 4*a+k, one-cycle registered read.
  always @(posedge clk) begin
    q0 <= D_BIT'({a0, 2'd0});
    q1 <= D_BIT'({a1, 2'd1});
    q2 <= D_BIT'({a2, 2'd2});
    q3 <= D_BIT'({a3, 2'd3});
  end

  int total = 0;
  int bad   = 0;
  int beats = 0;
  int dones = 0;
  logic [D_BIT:0] sb_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [D_BIT-1:0] exp_val(input int n);
`ifdef FHT_RD_BITREV_EN
    return D_BIT'(BR_TAB[n]);
`else
    return D_BIT'(n);
`endif
  endfunction

  task automatic push_run();
    for (int n = 0; n < N; n++) sb_q.push_back({(n == N - 1), exp_val(n)});
  endtask

  // Monitor: compares transferred beats, back-pressure stability and oDONE.
  initial begin
    logic             exp_done;
    logic             prev_stall;
    logic [D_BIT-1:0] prev_data;
    logic             prev_last;
    logic [D_BIT:0]   e;
    exp_done   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_done   = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (odone || exp_done) begin
          chk("done_pulse", 32'(odone), 32'(exp_done));
          chk("busy_at_done", 32'(obusy), 0);
          if (odone) dones++;
        end
        exp_done = 1'b0;
        if (prev_stall) begin
          chk("stall_valid", 32'(ovalid), 1);
          chk("stall_data", 32'(odata), 32'(prev_data));
          chk("stall_last", 32'(olast), 32'(prev_last));
        end
        prev_stall = ovalid && !ready;
        prev_data  = odata;
        prev_last  = olast;
        if (ovalid && ready) begin
          $display("beat %0d data=%0d last=%0d", beats, odata, olast);
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got data %0d want no beat", odata);
          end else begin
            e = sb_q.pop_front();
            chk("beat_data", 32'(odata), 32'(e[D_BIT-1:0]));
            chk("beat_last", 32'(olast), 32'(e[D_BIT]));
            exp_done = e[D_BIT];
          end
          beats++;
        end
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rand_ready);
    int c;
    int d0;
    c  = 0;
    d0 = dones;
    while (dones == d0 && c < budget) begin
      if (rand_ready) ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      c++;
    end
    ready = 1'b1;
    chk("done_seen", 32'(dones != d0), 1);
  endtask

  task automatic post_run(input string nm);
    repeat (3) @(posedge clk);
    #1;
    chk({nm, "_sb_empty"}, 32'(sb_q.size()), 0);
    chk({nm, "_idle_valid"}, 32'(ovalid), 0);
    chk({nm, "_idle_busy"}, 32'(obusy), 0);
    chk({nm, "_hold_data"}, 32'(odata), 32'(exp_val(N - 1)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int c;
    int b0;
    logic [A_BIT-1:0] a_mid;
    rst_n = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(ovalid), 0);
    chk("rst_data", 32'(odata), 0);
    chk("rst_last", 32'(olast), 0);
    chk("rst_busy", 32'(obusy), 0);
    chk("rst_done", 32'(odone), 0);
    chk("rst_addr", 32'({a0, a1, a2, a3}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Run 1: natural flow with iREADY high, latency and address checks.
    ready = 1'b1;
    push_run();
    chk("busy_before_start", 32'(obusy), 0);
    pulse_start();
    lat = 1;
    chk("busy_t1", 32'(obusy), 1);
    chk("addr_t1", 32'(a0), 0);
    while (!ovalid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first_valid_latency", 32'(lat), 32'(2 + RD_LAT));
    repeat (2) @(posedge clk);
    #1;
    chk("addr_idx4", 32'(a2), 32'(exp_val(4) >> 2));
    wait_done(4 * N + 100, 1'b0);
    post_run("run1");

    // Run 2: random back-pressure.
    push_run();
    pulse_start();
    wait_done(16 * N + 200, 1'b1);
    post_run("run2");

    // Run 3: sink stalled 20 cycles after first valid.
    ready = 1'b0;
    push_run();
    pulse_start();
    c = 0;
    while (!ovalid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk("stall_first_valid", 32'(ovalid), 1);
    repeat (10) @(posedge clk);
    #1;
    a_mid = a1;
    repeat (10) @(posedge clk);
    #1;
    chk("stall_fifo_full", 32'(dut.u_fifo.o_count), 32'(FD));
    chk("stall_addr_frozen", 32'(a1), 32'(a_mid));
    chk("stall_addr_value", 32'(a1), 32'(exp_val(FD - 1) >> 2));
    ready = 1'b1;
    wait_done(4 * N + 100, 1'b0);
    post_run("run3");

    // Run 4: reset mid-stream, then restart with ignored extra iSTARTs.
    push_run();
    b0 = beats;
    pulse_start();
    c = 0;
    while ((beats - b0) < RST_BEAT && c < 4 * N) begin
      @(negedge clk); #1;
      c++;
    end
    chk("reach_rst_beat", 32'(beats - b0), 32'(RST_BEAT));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ovalid), 0);
    chk("arst_data", 32'(odata), 0);
    chk("arst_last", 32'(olast), 0);
    chk("arst_busy", 32'(obusy), 0);
    chk("arst_addr", 32'({a0, a1, a2, a3}), 0);
    sb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_run();
    b0 = beats;
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    pulse_start();
    repeat (N / 4) @(posedge clk);
    #1;
    pulse_start();
    wait_done(4 * N + 100, 1'b0);
    post_run("run4");
    chk("run4_beats", 32'(beats - b0), 32'(N));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
